// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM ramp sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Full-scale duty (100%) for a resolution of r bits.
  function automatic int duty_max(input int r);
    return 32'sd1 << r;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel into the ramp sequencer: valid/ready plus ramp parameters.
interface pwm_ramp_ctrl_if #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int STEP_W     = 4,
  parameter int DWELL_W    = 8
);
  logic                  valid;
  logic                  ready;
  logic [R:0]            target;
  logic [STEP_W-1:0]     step;
  logic [DWELL_W-1:0]    dwell;
  logic [TIMER_BITS-1:0] fv;

  modport master (output valid, target, step, dwell, fv, input ready);
  modport slave  (input valid, target, step, dwell, fv, output ready);
endinterface

// File: rtl/pwm_period_div.sv
// Counts PWM period wraps and flags the wrap on which a ramp step is due.
module pwm_period_div #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               tick,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step_en
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Next dwell count; clear wins over a coincident tick.
  always_comb begin
    cnt_d   = cnt_q;
    step_en = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q < dwell) begin
        cnt_d = cnt_q + DWELL_W'(1);
      end else begin
        cnt_d   = '0;
        step_en = 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer ahead of the PWM core: ramps duty toward a
// commanded target one step per (dwell+1) periods, all updates on period wraps.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int STEP_W     = 4,
  parameter int DWELL_W    = 8,
  parameter int DEFAULT_FV = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  period_start,
  input  logic                  abort,
  pwm_ramp_ctrl_if.slave        cmd,
  output logic [R:0]            duty_out,
  output logic [TIMER_BITS-1:0] final_value_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [R+1:0] DUTY_MAX = (R+2)'(duty_max(R));

  state_e                state_q, state_d;
  logic [R:0]            duty_q, duty_d;
  logic [R:0]            target_q, target_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [TIMER_BITS-1:0] fv_out_q, fv_out_d;
  logic [TIMER_BITS-1:0] fv_shadow_q, fv_shadow_d;
  logic                  fv_pend_q, fv_pend_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic                  accept_s;
  logic                  tick_s;
  logic                  step_en_s;
  logic [R+1:0]          duty_ext_s, tgt_ext_s, step_ext_s, diff_s, next_s, cmd_tgt_ext_s;

  // abort masks ready in the same cycle so a coincident command is never taken.
  assign cmd.ready = ready_q & ~abort;
  assign accept_s  = cmd.valid & ready_q & ~abort;
  assign tick_s    = period_start & (state_q == ST_RAMP);

  pwm_period_div #(.DWELL_W(DWELL_W)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_s | abort),
    .tick    (tick_s),
    .dwell   (dwell_q),
    .step_en (step_en_s)
  );

  assign duty_ext_s    = {1'b0, duty_q};
  assign tgt_ext_s     = {1'b0, target_q};
  assign step_ext_s    = (R+2)'(step_q);
  assign cmd_tgt_ext_s = {1'b0, cmd.target};
  assign diff_s        = (tgt_ext_s >= duty_ext_s) ? (tgt_ext_s - duty_ext_s)
                                                   : (duty_ext_s - tgt_ext_s);
  assign next_s        = (tgt_ext_s >= duty_ext_s) ? (duty_ext_s + step_ext_s)
                                                   : (duty_ext_s - step_ext_s);

  // Sequencer next-state: abort, then accept, then period-aligned ramp work.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    fv_out_d    = fv_out_q;
    fv_shadow_d = fv_shadow_q;
    fv_pend_d   = fv_pend_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      duty_d    = '0;
      fv_pend_d = 1'b0;
    end else if (accept_s) begin
      target_d    = (cmd_tgt_ext_s > DUTY_MAX) ? DUTY_MAX[R:0] : cmd.target;
      step_d      = (cmd.step == '0) ? STEP_W'(1) : cmd.step;
      dwell_d     = cmd.dwell;
      fv_shadow_d = cmd.fv;
      fv_pend_d   = 1'b1;
      state_d     = ST_RAMP;
    end else if (tick_s) begin
      if (fv_pend_q) begin
        fv_out_d  = fv_shadow_q;
        fv_pend_d = 1'b0;
      end else begin
        fv_out_d = fv_out_q;
      end
      if (step_en_s) begin
        if (diff_s <= step_ext_s) begin
          duty_d  = target_q;
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end else begin
          duty_d = next_s[R:0];
        end
      end else begin
        duty_d = duty_q;
      end
    end else begin
      state_d = state_q;
    end
    busy_d  = (state_d == ST_RAMP);
    ready_d = (state_d != ST_RAMP);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      fv_out_q    <= TIMER_BITS'(DEFAULT_FV);
      fv_shadow_q <= '0;
      fv_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      fv_out_q    <= fv_out_d;
      fv_shadow_q <= fv_shadow_d;
      fv_pend_q   <= fv_pend_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign duty_out        = duty_q;
  assign final_value_out = fv_out_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected duty/done events queued at
// command time and matched against every observed duty change or done pulse.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        period_start = 1'b0;
  logic        abort = 1'b0;
  logic [8:0]  duty_out;
  logic [14:0] final_value_out;
  logic        busy;
  logic        done;

  pwm_ramp_ctrl_if #(.R(8), .TIMER_BITS(15), .STEP_W(4), .DWELL_W(8)) cmd_if ();

  pwm_ramp_ctrl #(.R(8), .TIMER_BITS(15), .STEP_W(4), .DWELL_W(8), .DEFAULT_FV(1000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .period_start    (period_start),
    .abort           (abort),
    .cmd             (cmd_if),
    .duty_out        (duty_out),
    .final_value_out (final_value_out),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [8:0] duty;
    logic       done;
    int         pulses;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   pcnt = 0;
  int   gen_cnt = 0;
  int   model_duty = 0;
  logic [8:0] prev_duty = 9'd0;
  bit   acc_s, ps_s;
  exp_t e;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  // period_start: one-cycle pulse every 16 clocks
  always @(negedge clk) begin
    if (!reset_n) begin
      gen_cnt = 0;
      period_start = 1'b0;
    end else begin
      gen_cnt = (gen_cnt == 15) ? 0 : gen_cnt + 1;
      period_start = (gen_cnt == 15);
    end
  end

  always @(posedge clk) begin
    acc_s = cmd_if.valid && cmd_if.ready;
    ps_s  = period_start;
    if (acc_s) pcnt = 0;
    else if (ps_s) pcnt++;
    #1;
    if (reset_n && (duty_out !== prev_duty || done === 1'b1)) begin
      check_eq("sb_has_entry", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("duty", duty_out, e.duty);
        check_eq("done", done, e.done);
        if (e.pulses >= 0) check_eq("pulses", pcnt, e.pulses);
      end
    end
    prev_duty = duty_out;
  end

  task automatic push_ramp(input int tgt, input int stp, input int dwell);
    int d, t, s, diff;
    d = model_duty;
    t = (tgt > 256) ? 256 : tgt;
    s = (stp == 0) ? 1 : stp;
    for (int k = 1; k <= 600; k++) begin
      diff = (t >= d) ? t - d : d - t;
      if (diff <= s) begin
        exp_q.push_back('{duty: t[8:0], done: 1'b1, pulses: k * (dwell + 1)});
        break;
      end
      d = (t > d) ? d + s : d - s;
      exp_q.push_back('{duty: d[8:0], done: 1'b0, pulses: k * (dwell + 1)});
    end
    model_duty = t;
  endtask

  task automatic drive_cmd(input int tgt, input int stp, input int dwell, input int fv);
    cmd_if.valid  = 1'b1;
    cmd_if.target = tgt[8:0];
    cmd_if.step   = stp[3:0];
    cmd_if.dwell  = dwell[7:0];
    cmd_if.fv     = fv[14:0];
  endtask

  // Present a command (optionally on a period_start cycle) and wait for acceptance.
  task automatic send(input int tgt, input int stp, input int dwell, input int fv, input bit align);
    int n;
    @(negedge clk); #1;
    if (align) begin
      for (n = 0; n < 40 && !period_start; n++) begin
        @(negedge clk); #1;
      end
    end
    drive_cmd(tgt, stp, dwell, fv);
    for (n = 0; n < 8000 && !cmd_if.ready; n++) begin
      @(negedge clk); #1;
    end
    if (!cmd_if.ready) check_eq("accept_timeout", cmd_if.ready, 1);
    push_ramp(tgt, stp, dwell);
    @(posedge clk);
    @(negedge clk);
    cmd_if.valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int n = 0; n < bound && exp_q.size() != 0; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    cmd_if.valid = 1'b0;
    drive_cmd(0, 0, 0, 0);
    cmd_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_duty", duty_out, 0);
    check_eq("rst_fv", final_value_out, 1000);
    check_eq("rst_ready", cmd_if.ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Soft start 0 -> 100, step 10, new final value on first wrap.
    send(100, 10, 0, 500, 1'b0);
    #1;
    check_eq("fv_before_wrap", final_value_out, 1000);
    check_eq("busy_ramp", busy, 1);
    for (n = 0; n < 40 && pcnt < 1; n++) @(negedge clk);
    #1;
    check_eq("fv_after_wrap", final_value_out, 500);
    wait_drain(400);
    check_eq("hold_ready", cmd_if.ready, 1);
    check_eq("hold_busy", busy, 0);

    // Soft stop 100 -> 5 with two extra periods between steps.
    send(5, 10, 2, 500, 1'b0);
    wait_drain(800);

    // Clamped target and zero step, then a command held off during the ramp.
    send(300, 0, 0, 800, 1'b0);
    @(negedge clk); #1;
    drive_cmd(0, 4, 0, 900);
    repeat (20) @(negedge clk);
    #1;
    check_eq("held_ready", cmd_if.ready, 0);
    check_eq("held_busy", busy, 1);
    send(0, 4, 0, 900, 1'b0);

    // Abort mid-ramp at duty 60 with a simultaneous command.
    for (n = 0; n < 2000 && duty_out != 9'd60; n++) begin
      @(negedge clk); #1;
    end
    check_eq("reach_60", duty_out, 60);
    exp_q.delete();
    exp_q.push_back('{duty: 9'd0, done: 1'b0, pulses: -1});
    model_duty = 0;
    abort = 1'b1;
    drive_cmd(50, 5, 0, 123);
    #1;
    check_eq("abort_ready", cmd_if.ready, 0);
    @(negedge clk);
    abort = 1'b0;
    cmd_if.valid = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_idle_ready", cmd_if.ready, 1);
    check_eq("abort_fv", final_value_out, 900);
    wait_drain(100);

    // Accept coincident with period_start: that wrap is not counted.
    send(20, 10, 1, 700, 1'b1);
    #1;
    check_eq("align_fv_kept", final_value_out, 900);
    wait_drain(300);
    check_eq("align_fv", final_value_out, 700);

    // Target equal to current duty: done after dwell+1 wraps, duty unchanged.
    send(20, 3, 1, 700, 1'b0);
    wait_drain(300);
    check_eq("eq_busy", busy, 0);

    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
